// File: rtl/bcd_entry.sv
// Keypad-driven 3-digit signed BCD entry register with edge-detected key events.
// Optional feature: define BACKSPACE_EN to enable key E as backspace while entering.
module bcd_entry (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] BCD0,
  output logic [3:0] BCD1,
  output logic [3:0] BCD2,
  output logic [3:0] BCD3,
  output logic [1:0] digit_count,
  output logic       entry_done
);

  localparam logic [3:0] BLANK   = 4'hF;
  localparam logic [3:0] NEG     = 4'hB;
  localparam logic [3:0] K_NEG   = 4'hA;
  localparam logic [3:0] K_CLEAR = 4'hC;
  localparam logic [3:0] K_ENTER = 4'hD;
`ifdef BACKSPACE_EN
  localparam logic [3:0] K_BKSP  = 4'hE;
`endif

  typedef enum logic [1:0] {EMPTY, ENTRY, HELD} state_t;

  state_t     state_q, state_d;
  logic       kv_q;
  logic [3:0] bcd0_q, bcd0_d, bcd1_q, bcd1_d, bcd2_q, bcd2_d, bcd3_q, bcd3_d;
  logic [1:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic       key_ev;

  // A held key yields a single event: only the rising edge of key_valid counts.
  assign key_ev = key_valid & ~kv_q;

  always_comb begin
    state_d = state_q;
    bcd0_d  = bcd0_q;
    bcd1_d  = bcd1_q;
    bcd2_d  = bcd2_q;
    bcd3_d  = bcd3_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (key_ev) begin
      if (key_code <= 4'd9) begin
        case (state_q)
          EMPTY: begin
            bcd0_d  = key_code;
            cnt_d   = 2'd1;
            state_d = ENTRY;
          end
          ENTRY: begin
            // A lone zero is replaced rather than shifted, so no leading zeros appear.
            if (cnt_q == 2'd1 && bcd0_q == 4'd0) begin
              bcd0_d = key_code;
            end else if (cnt_q != 2'd3) begin
              bcd2_d = bcd1_q;
              bcd1_d = bcd0_q;
              bcd0_d = key_code;
              cnt_d  = cnt_q + 2'd1;
            end
          end
          HELD: begin
            bcd3_d  = BLANK;
            bcd2_d  = BLANK;
            bcd1_d  = BLANK;
            bcd0_d  = key_code;
            cnt_d   = 2'd1;
            state_d = ENTRY;
          end
          default: state_d = EMPTY;
        endcase
      end else begin
        case (key_code)
          K_NEG: begin
            if (state_q == HELD) begin
              bcd3_d  = NEG;
              bcd2_d  = BLANK;
              bcd1_d  = BLANK;
              bcd0_d  = BLANK;
              cnt_d   = 2'd0;
              state_d = EMPTY;
            end else begin
              bcd3_d = (bcd3_q == NEG) ? BLANK : NEG;
            end
          end
          K_CLEAR: begin
            bcd3_d  = BLANK;
            bcd2_d  = BLANK;
            bcd1_d  = BLANK;
            bcd0_d  = BLANK;
            cnt_d   = 2'd0;
            state_d = EMPTY;
          end
          K_ENTER: begin
            if (state_q == ENTRY) begin
              done_d  = 1'b1;
              state_d = HELD;
            end
          end
`ifdef BACKSPACE_EN
          K_BKSP: begin
            if (state_q == ENTRY) begin
              bcd0_d = bcd1_q;
              bcd1_d = bcd2_q;
              bcd2_d = BLANK;
              cnt_d  = cnt_q - 2'd1;
              if (cnt_q == 2'd1) state_d = EMPTY;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      kv_q    <= 1'b0;
      bcd0_q  <= BLANK;
      bcd1_q  <= BLANK;
      bcd2_q  <= BLANK;
      bcd3_q  <= BLANK;
      cnt_q   <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kv_q    <= key_valid;
      bcd0_q  <= bcd0_d;
      bcd1_q  <= bcd1_d;
      bcd2_q  <= bcd2_d;
      bcd3_q  <= bcd3_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign BCD0        = bcd0_q;
  assign BCD1        = bcd1_q;
  assign BCD2        = bcd2_q;
  assign BCD3        = bcd3_q;
  assign digit_count = cnt_q;
  assign entry_done  = done_q;

endmodule
